// File: rtl/data_bus_periph.sv
// data_bus_periph: memory-side slave for the multi-cycle CPU.
// The byte address is decoded into a word RAM or a peripheral window holding
// a reloadable timer, an LED register, a free-running cycle counter and a
// multiplexed 4-digit seven-segment driver.
//
// Bus handshake: there is no valid/ready pair. mem_read qualifies the
// combinational rdata in the same cycle. mem_write commits on the next rising
// edge. When both are high, rdata shows the value held before that write.
module data_bus_periph #(
  parameter int RAM_WORDS = 256,
  parameter int SCAN_DIV  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [7:0]  leds,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        timer_irq
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PW     = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    S_DIG0 = 2'd0,
    S_DIG1 = 2'd1,
    S_DIG2 = 2'd2,
    S_DIG3 = 2'd3
  } scan_state_t;

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [7:0]  r_led;
  logic [15:0] r_digits;
  logic [31:0] r_systick;
  logic [PW-1:0] r_presc;
  scan_state_t r_state;
  scan_state_t w_state_nxt;

  logic          w_ram_sel;
  logic          w_per_sel;
  logic [2:0]    w_reg;
  logic [RAM_AW-1:0] w_ram_idx;
  logic          w_wr_th;
  logic          w_wr_tl;
  logic          w_wr_tcon;
  logic          w_wr_led;
  logic          w_wr_digits;
  logic          w_tl_ovf;
  logic          w_presc_wrap;
  logic [3:0]    w_nibble;
  logic [6:0]    w_hex;
  logic          w_unused;

  // Address decode: RAM occupies the low RAM_WORDS*4 bytes only, so any set
  // bit above the RAM index range makes the access unmapped. The peripheral
  // window is the 32-byte block at 0x4000_0000.
  assign w_ram_sel = (addr[31:RAM_AW+2] == '0);
  assign w_per_sel = (addr[31:5] == 27'h0200_0000);
  assign w_reg     = addr[4:2];
  assign w_ram_idx = addr[RAM_AW+1:2];
  assign w_unused  = &{1'b0, addr[1:0]};

  assign w_wr_th     = mem_write & w_per_sel & (w_reg == 3'd0);
  assign w_wr_tl     = mem_write & w_per_sel & (w_reg == 3'd1);
  assign w_wr_tcon   = mem_write & w_per_sel & (w_reg == 3'd2);
  assign w_wr_led    = mem_write & w_per_sel & (w_reg == 3'd3);
  assign w_wr_digits = mem_write & w_per_sel & (w_reg == 3'd4);

  assign w_tl_ovf     = r_tcon[0] & (r_tl == 32'hFFFF_FFFF);
  assign w_presc_wrap = (r_presc == PW'(SCAN_DIV - 1));

  // Word RAM write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_write && w_ram_sel) begin
      r_ram[w_ram_idx] <= wdata;
    end
  end

  // Plain CPU-writable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th     <= '0;
      r_led    <= '0;
      r_digits <= '0;
    end else begin
      if (w_wr_th)     r_th     <= wdata;
      if (w_wr_led)    r_led    <= wdata[7:0];
      if (w_wr_digits) r_digits <= wdata[15:0];
    end
  end

  // Timer count and control; a CPU write to TL or TCON wins over the timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_tl) begin
        r_tl <= wdata;
      end else if (r_tcon[0]) begin
        r_tl <= w_tl_ovf ? r_th : r_tl + 32'd1;
      end
      if (w_wr_tcon) begin
        r_tcon <= wdata[2:0];
      end else if (w_tl_ovf && r_tcon[1]) begin
        r_tcon[2] <= 1'b1;
      end
    end
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_systick <= '0;
    else        r_systick <= r_systick + 32'd1;
  end

  // Scan prescaler counting 0..SCAN_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_presc <= '0;
    else if (w_presc_wrap) r_presc <= '0;
    else                   r_presc <= r_presc + PW'(1);
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_DIG0;
    else        r_state <= w_state_nxt;
  end

  // Scan FSM next state and digit outputs; digit advances on prescaler wrap.
  always_comb begin
    w_state_nxt = r_state;
    an          = 4'b1110;
    w_nibble    = r_digits[3:0];
    case (r_state)
      S_DIG0: begin
        an       = 4'b1110;
        w_nibble = r_digits[3:0];
        if (w_presc_wrap) w_state_nxt = S_DIG1;
      end
      S_DIG1: begin
        an       = 4'b1101;
        w_nibble = r_digits[7:4];
        if (w_presc_wrap) w_state_nxt = S_DIG2;
      end
      S_DIG2: begin
        an       = 4'b1011;
        w_nibble = r_digits[11:8];
        if (w_presc_wrap) w_state_nxt = S_DIG3;
      end
      default: begin
        an       = 4'b0111;
        w_nibble = r_digits[15:12];
        if (w_presc_wrap) w_state_nxt = S_DIG0;
      end
    endcase
  end

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    w_hex = 7'b1111111;
    case (w_nibble)
      4'h0: w_hex = 7'b1000000;
      4'h1: w_hex = 7'b1111001;
      4'h2: w_hex = 7'b0100100;
      4'h3: w_hex = 7'b0110000;
      4'h4: w_hex = 7'b0011001;
      4'h5: w_hex = 7'b0010010;
      4'h6: w_hex = 7'b0000010;
      4'h7: w_hex = 7'b1111000;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0010000;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b0000011;
      4'hC: w_hex = 7'b1000110;
      4'hD: w_hex = 7'b0100001;
      4'hE: w_hex = 7'b0000110;
      default: w_hex = 7'b0001110;
    endcase
  end

  assign seg       = {1'b1, w_hex};
  assign leds      = r_led;
  assign timer_irq = r_tcon[1] & r_tcon[2];

  // Combinational read mux; zero when not reading or unmapped.
  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (w_ram_sel) begin
        rdata = r_ram[w_ram_idx];
      end else if (w_per_sel) begin
        case (w_reg)
          3'd0:    rdata = r_th;
          3'd1:    rdata = r_tl;
          3'd2:    rdata = {29'd0, r_tcon};
          3'd3:    rdata = {24'd0, r_led};
          3'd4:    rdata = {16'd0, r_digits};
          3'd5:    rdata = r_systick;
          default: rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/data_bus_periph.md
# data_bus_periph

Memory-side slave of the multi-cycle CPU. It decodes each CPU memory access, computed from the PC or the registered ALU result, into either a word RAM or a memory-mapped peripheral window. The window holds a reloadable timer with interrupt flag, an LED register, a free-running cycle counter, and a multiplexed 4-digit seven-segment driver. Read data is combinational so the CPU's memory data register captures it at the end of the access cycle.

## Interface
Parameters:
- RAM_WORDS, 256: depth of data RAM in 32-bit words; power of two.
- SCAN_DIV, 1000: clk cycles each seven-segment digit stays lit; ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from CPU; addr[1:0] ignored.
- wdata  input  32  write data (CPU register B output).
- mem_read  input  1  read enable.
- mem_write  input  1  write enable.
- rdata  output  32  read data, combinational.
- leds  output  8  LED register.
- an  output  4  digit enables, active-low, one-hot.
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- timer_irq  output  1  TCON[1] & TCON[2].

## Operation
- Address map, word-aligned:
  - RAM: 0x0000_0000 to RAM_WORDS*4-1.
  - 0x4000_0000 TH: timer reload, R/W.
  - 0x4000_0004 TL: timer count, R/W.
  - 0x4000_0008 TCON: bit0 enable, bit1 irq enable, bit2 irq status; R/W; bits 31:3 read 0.
  - 0x4000_000C LED: bits 7:0, R/W.
  - 0x4000_0010 DIGITS: bits 15:0, four hex nibbles with digit 0 = bits 3:0; R/W.
  - 0x4000_0014 SYSTICK: read-only; writes are ignored.
- Any other address is unmapped: reads return 0, writes are ignored. This includes RAM-range addresses at or above RAM_WORDS*4.
- rdata is 0 whenever mem_read is 0. If mem_read and mem_write are both 1, the write commits and rdata shows the pre-write value.
- RAM write: synchronous on the edge when mem_write=1. RAM is not cleared by reset.
- Timer, when TCON[0]=1, per cycle:
  - If TL==0xFFFF_FFFF: TL←TH, and if TCON[1]=1 then TCON[2]←1.
  - Otherwise TL←TL+1.
- Timer collisions: a CPU write to TL or TCON in the same cycle overrides the timer update for that register. This means software clears TCON[2] by writing TCON.
- SYSTICK increments every cycle and wraps from 0xFFFF_FFFF to 0.
- Scan FSM: a prescaler counts 0..SCAN_DIV-1. When it wraps, the digit index advances 0→1→2→3→0.
  - an = ~(4'b0001 << idx).
  - seg[6:0] = active-low hex decode of DIGITS nibble idx; seg[7] = 1 (dp off).
  - Hex patterns for seg[6:0]: 0 = 1000000, 1 = 1111001, A = 0001000, F = 0001110.

## Timing
- Reset values (asserted asynchronously):
  - TH, TL, TCON, LED, DIGITS, SYSTICK, prescaler, idx = 0.
  - leds = 0, timer_irq = 0, an = 4'b1110, seg = 8'hC0.
- Read latency 0: rdata is valid in the same cycle as addr/mem_read.
- Write latency 1: a write is visible to a read in the next cycle.
- SYSTICK is read after its increment; the first post-reset read, in cycle k after release, returns k.
- Timer overflow: from TL=0xFFFF_FFFF with enable set, the next edge loads TH, and timer_irq rises on that same edge.
- A write to DIGITS changes seg no later than the next edge; the scan position is not reset by the write.
- Reset asserted mid-scan or mid-count: all counters return to 0 immediately. RAM contents are retained.

## Test plan
- Reset release → leds=0, an=1110, seg=C0, timer_irq=0. Read SYSTICK on cycle 5 → 5.
- Write 0xDEADBEEF to 0x0000_0010, then read 0x10 → DEADBEEF. Write and read 0x0000_0400 (RAM_WORDS=256) → reads 0. Read 0x4000_0018 → 0.
- TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3 → TL=FFFF_FFFF, then FFFF_FFF0. timer_irq=1 on the second edge. Write TCON=3 → irq clears.
- Overflow edge coinciding with a CPU write TL=5 → TL reads 5, TCON[2] still set.
- SCAN_DIV=2, DIGITS=0x10AF:
  - an sequence 1110,1101,1011,0111, each for 2 cycles.
  - seg sequence 8E,88,C0,F9.
- mem_read=1 and mem_write=1 to LED with wdata=0x5A → rdata shows the old LED value. leds=0x5A after the edge.
